freq_meter: RTL and testbench

FREQ_METER -- requirements
Module: freq_meter

---
 rtl/freq_meter_pkg.sv | 37 +++
 rtl/bin2bcd.sv | 75 +++++++
 rtl/freq_meter.sv | 75 +++++++
 tb/tb_freq_meter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// freq_meter shared constants, converter state encoding and BCD helpers.
// Items: default gate length, counter width, BCD width, FSM states.
package freq_meter_pkg;

  localparam int GATE_CYCLES_DEF = 100000000;
  localparam int CNT_W_DEF = 27;
  localparam int BCD_W = 32;
  localparam int BCD_MAX = 99999999;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } bcd_state_t;

  // Add 3 to every digit >= 5 ahead of a double-dabble shift.
  function automatic logic [BCD_W-1:0] bcd_adj(
    input logic [BCD_W-1:0] v
  );
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (r[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = r[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  // Counts past eight decimal digits read as all nines.
  function automatic logic [BCD_W-1:0] bcd_clamp(
    input logic [BCD_W-1:0] v
  );
    return (v > BCD_W'(BCD_MAX)) ? BCD_W'(BCD_MAX) : v;
  endfunction

endpackage

// File: rtl/bin2bcd.sv
// bin2bcd: sequential double-dabble, one bit per cycle (W cycles).
// Ports: clk, rstn, start, bin[W], bcd[32], done. Built with FREQ_METER_BCD_EN.
`ifdef FREQ_METER_BCD_EN
import freq_meter_pkg::*;

module bin2bcd #(
  parameter int W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [W-1:0]     bin,
  output logic [BCD_W-1:0] bcd,
  output logic             done
);

  localparam int CW = $clog2(W + 1);

  bcd_state_t       state;
  bcd_state_t       state_nx;
  logic [CW-1:0]    cnt;
  logic [W-1:0]     sh;
  logic [BCD_W-1:0] acc;
  logic [BCD_W-1:0] adj;
  logic [BCD_W-1:0] acc_nx;
  logic             last;

  assign last   = (cnt == CW'(W - 1));
  assign adj    = bcd_adj(acc);
  assign acc_nx = (adj << 1) | BCD_W'(sh[W-1]);
  assign done   = (state == DONE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
      sh  <= '0;
      acc <= '0;
      bcd <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt <= '0;
            acc <= '0;
            sh  <= W'(bcd_clamp(BCD_W'(bin)));
          end
        end
        SHIFT: begin
          acc <= acc_nx;
          sh  <= sh << 1;
          cnt <= cnt + CW'(1);
          if (last) bcd <= acc_nx;
        end
        default: ;
      endcase
    end
  end

endmodule
`endif

// File: rtl/freq_meter.sv
// freq_meter: counts i_sig rising edges per GATE_CYCLES-cycle gate.
// Ports: clk, rstn, i_en, i_sig -> o_freq/o_valid, o_bcd/o_bcd_valid (FREQ_METER_BCD_EN).
import freq_meter_pkg::*;

module freq_meter #(
  parameter int GATE_CYCLES = GATE_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_en,
  input  logic             i_sig,
  output logic [CNT_W-1:0] o_freq,
  output logic             o_valid,
  output logic [BCD_W-1:0] o_bcd,
  output logic             o_bcd_valid
);

  localparam int GW = $clog2(GATE_CYCLES);

  logic [2:0]       sync;
  logic             rise;
  logic [GW-1:0]    gcnt;
  logic             term;
  logic [CNT_W-1:0] ecnt;
  logic [CNT_W-1:0] ecnt_inc;
  logic [CNT_W-1:0] ecnt_nx;

  assign rise     = sync[1] & ~sync[2];
  assign term     = i_en && (gcnt == GW'(GATE_CYCLES - 1));
  assign ecnt_inc = (&ecnt) ? ecnt : ecnt + CNT_W'(1);
  assign ecnt_nx  = rise ? ecnt_inc : ecnt;

  // The terminal-cycle edge lands in o_freq; the next gate starts empty.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync    <= '0;
      gcnt    <= '0;
      ecnt    <= '0;
      o_freq  <= '0;
      o_valid <= 1'b0;
    end else begin
      sync    <= {sync[1:0], i_sig};
      o_valid <= term;
      if (!i_en) begin
        gcnt <= '0;
        ecnt <= '0;
      end else if (term) begin
        gcnt   <= '0;
        ecnt   <= '0;
        o_freq <= ecnt_nx;
      end else begin
        gcnt <= gcnt + GW'(1);
        ecnt <= ecnt_nx;
      end
    end
  end

`ifdef FREQ_METER_BCD_EN
  bin2bcd #(
    .W(CNT_W)
  ) u_bcd (
    .clk  (clk),
    .rstn (rstn),
    .start(o_valid),
    .bin  (o_freq),
    .bcd  (o_bcd),
    .done (o_bcd_valid)
  );
`else
  assign o_bcd       = '0;
  assign o_bcd_valid = 1'b0;
`endif

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: scoreboard bench for freq_meter on three parameter sets.
// Expected frequency/BCD results and their arrival cycles are queued.
module tb_freq_meter;

  typedef struct {
    int unsigned val;
    int unsigned at;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic a_rstn = 1'b0;
  logic a_en = 1'b0, b_en = 1'b0, c_en = 1'b0;
  logic a_sig = 1'b0, b_sig = 1'b0, c_sig = 1'b0;
  logic a_mode = 1'b0;
  int unsigned cyc = 0;
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  logic [26:0] a_freq, c_freq;
  logic [3:0]  b_freq;
  logic        a_vld, b_vld, c_vld;
  logic [31:0] a_bcd, b_bcd, c_bcd;
  logic        a_bv, b_bv, c_bv;

  logic [31:0] frq [3];
  logic        vld [3];
  logic [31:0] bcd [3];
  logic        bvld [3];

  exp_t fq [3][$];
  exp_t bq [3][$];
  exp_t me;

  freq_meter #(.GATE_CYCLES(1000)) u_a (
    .clk(clk), .rstn(a_rstn), .i_en(a_en), .i_sig(a_sig),
    .o_freq(a_freq), .o_valid(a_vld),
    .o_bcd(a_bcd), .o_bcd_valid(a_bv)
  );

  freq_meter #(.GATE_CYCLES(1000), .CNT_W(4)) u_b (
    .clk(clk), .rstn(rstn), .i_en(b_en), .i_sig(b_sig),
    .o_freq(b_freq), .o_valid(b_vld),
    .o_bcd(b_bcd), .o_bcd_valid(b_bv)
  );

  freq_meter #(.GATE_CYCLES(2468)) u_c (
    .clk(clk), .rstn(rstn), .i_en(c_en), .i_sig(c_sig),
    .o_freq(c_freq), .o_valid(c_vld),
    .o_bcd(c_bcd), .o_bcd_valid(c_bv)
  );

  assign frq[0] = 32'(a_freq);
  assign frq[1] = 32'(b_freq);
  assign frq[2] = 32'(c_freq);
  assign vld[0] = a_vld;
  assign vld[1] = b_vld;
  assign vld[2] = c_vld;
  assign bcd[0] = a_bcd;
  assign bcd[1] = b_bcd;
  assign bcd[2] = c_bcd;
  assign bvld[0] = a_bv;
  assign bvld[1] = b_bv;
  assign bvld[2] = c_bv;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Waves derive from cyc: A period 10 (or held 1), B period 4, C period 2.
  initial begin
    forever begin
      @(negedge clk);
      a_sig = a_mode | ((cyc % 10) >= 5);
      b_sig = (cyc % 4) >= 2;
      c_sig = cyc[0];
    end
  end

  task automatic chk(string nm, int unsigned act, int unsigned exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)",
                  nm, act, exp, cyc);
  endtask

  task automatic expect_out(int i, int unsigned f, int unsigned b,
                            int unsigned t, int unsigned cw);
    exp_t e;
    e.val = f;
    e.at  = t;
    fq[i].push_back(e);
`ifdef FREQ_METER_BCD_EN
    e.val = b;
    e.at  = t + cw + 1;
    bq[i].push_back(e);
`else
    if (b != 0 && cw == 0) $display("note: unused bcd %0d", b);
`endif
  endtask

  task automatic wait_until(int unsigned t);
    while (cyc < t) @(negedge clk);
  endtask

  function automatic int unsigned pending();
    int unsigned n = 0;
    for (int i = 0; i < 3; i++) n += fq[i].size() + bq[i].size();
    return n;
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (vld[i]) begin
        if (fq[i].size() == 0) begin
          chk($sformatf("u%0d_unexpected_valid", i), 1, 0);
        end else begin
          me = fq[i].pop_front();
          chk($sformatf("u%0d_freq", i), frq[i], me.val);
          chk($sformatf("u%0d_valid_cyc", i), cyc, me.at);
        end
`ifndef FREQ_METER_BCD_EN
        chk($sformatf("u%0d_bcd_tied", i), bcd[i], 0);
`endif
      end
      if (bvld[i]) begin
        if (bq[i].size() == 0) begin
          chk($sformatf("u%0d_unexpected_bcd_valid", i), 1, 0);
        end else begin
          me = bq[i].pop_front();
          chk($sformatf("u%0d_bcd", i), bcd[i], me.val);
          chk($sformatf("u%0d_bcd_cyc", i), cyc, me.at);
        end
      end
    end
  end

  initial begin
    int unsigned k;
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d_rst_freq", i), frq[i], 0);
      chk($sformatf("u%0d_rst_valid", i), 32'(vld[i]), 0);
      chk($sformatf("u%0d_rst_bcd", i), bcd[i], 0);
      chk($sformatf("u%0d_rst_bcd_valid", i), 32'(bvld[i]), 0);
    end
    @(negedge clk);
    rstn = 1'b1;
    a_rstn = 1'b1;
    repeat (20) @(negedge clk);

    fork
      begin : run_b
        int unsigned kb;
        kb = cyc;
        b_en = 1'b1;
        expect_out(1, 15, 'h15, kb + 1000, 4);
        expect_out(1, 15, 'h15, kb + 2000, 4);
        wait_until(kb + 2500);
        b_en = 1'b0;
      end
      begin : run_c
        int unsigned kc;
        kc = cyc;
        c_en = 1'b1;
        expect_out(2, 1234, 'h1234, kc + 2468, 27);
        wait_until(kc + 2568);
        c_en = 1'b0;
      end
    join_none

    // Three full gates at 100 edges, then drop i_en at gate cycle 500.
    k = cyc;
    a_en = 1'b1;
    expect_out(0, 100, 'h100, k + 1000, 27);
    expect_out(0, 100, 'h100, k + 2000, 27);
    expect_out(0, 100, 'h100, k + 3000, 27);
    wait_until(k + 3500);
    a_en = 1'b0;
    repeat (50) @(negedge clk);
    chk("u0_hold_freq", frq[0], 100);

    // Re-enable, then reset at gate cycle 700 of the second gate.
    k = cyc;
    a_en = 1'b1;
    expect_out(0, 100, 'h100, k + 1000, 27);
    wait_until(k + 1700);
    a_rstn = 1'b0;
    #1;
    chk("u0_mid_rst_freq", frq[0], 0);
    chk("u0_mid_rst_valid", 32'(vld[0]), 0);
    chk("u0_mid_rst_bcd", bcd[0], 0);
    chk("u0_mid_rst_bcd_valid", 32'(bvld[0]), 0);
    repeat (3) @(negedge clk);
    do @(negedge clk); while ((cyc % 10) != 0);
    a_rstn = 1'b1;
    k = cyc;
    expect_out(0, 100, 'h100, k + 1000, 27);
    wait_until(k + 1040);
    a_en = 1'b0;

    // Signal held high across a whole gate.
    a_mode = 1'b1;
    repeat (20) @(negedge clk);
    k = cyc;
    a_en = 1'b1;
    expect_out(0, 0, 'h0, k + 1000, 27);
    wait_until(k + 1040);
    a_en = 1'b0;

    k = cyc;
    while (pending() > 0 && cyc < k + 5000) @(negedge clk);
    chk("drain_pending", pending(), 0);
    repeat (10) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
